reg_status_file: RTL and testbench

- Architectural register file plus per-register rename status (busy bit and ROB tag) for the out-of-order RISC-V core.
- Consumes the ROB's register-commit stream and its rollback indication.
- Accepts rename requests from the decoder at issue.
- Answers the decoder's combinational operand queries with either a committed value or the ROB tag of the pending producer.

---
 rtl/reg_status_file_if.sv | 49 ++++
 rtl/reg_status_file.sv | 93 +++++++++
 tb/tb_reg_status_file.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_status_file_if.sv
// Decoder/ROB-facing bus of the register status file.
// Groups commit, issue, rollback, operand queries and the debug view.
//   master : ROB/decoder side, drives control and query ids
//   slave  : reg_status_file, returns operand values/tags and dbg_regs
interface reg_status_file_if #(
   parameter int ROB_W = 4,
   parameter int XLEN  = 32
);
   logic                 rdy;
   logic                 rollback;
   logic                 commit_reg_config;
   logic [4:0]           commit_reg_id;
   logic [XLEN-1:0]      commit_reg_value;
   logic [ROB_W-1:0]     commit_reg_rob;
   logic                 issue_config;
   logic [4:0]           issue_rd;
   logic [ROB_W-1:0]     issue_rob;
   logic [4:0]           rs1_id;
   logic [XLEN-1:0]      rs1_value;
   logic                 rs1_busy;
   logic [ROB_W-1:0]     rs1_tag;
   logic [4:0]           rs2_id;
   logic [XLEN-1:0]      rs2_value;
   logic                 rs2_busy;
   logic [ROB_W-1:0]     rs2_tag;
   logic [32*XLEN-1:0]   dbg_regs;

   modport master (
      output rdy, rollback,
      output commit_reg_config, commit_reg_id,
      output commit_reg_value, commit_reg_rob,
      output issue_config, issue_rd, issue_rob,
      output rs1_id, rs2_id,
      input  rs1_value, rs1_busy, rs1_tag,
      input  rs2_value, rs2_busy, rs2_tag,
      input  dbg_regs
   );

   modport slave (
      input  rdy, rollback,
      input  commit_reg_config, commit_reg_id,
      input  commit_reg_value, commit_reg_rob,
      input  issue_config, issue_rd, issue_rob,
      input  rs1_id, rs2_id,
      output rs1_value, rs1_busy, rs1_tag,
      output rs2_value, rs2_busy, rs2_tag,
      output dbg_regs
   );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status.
// Ports: clk, rst (async, active high), rf (slave bus: commit,
// issue, rollback, two combinational operand queries, dbg_regs).
module reg_status_file #(
   parameter int ROB_W = 4,
   parameter int XLEN  = 32
) (
   input logic              clk,
   input logic              rst,
   reg_status_file_if.slave rf
);
   logic [31:0][XLEN-1:0]  value_q, value_d;
   logic [31:0]            busy_q, busy_d;
   logic [31:0][ROB_W-1:0] tag_q, tag_d;

   logic cm_fire;
   logic is_fire;
   logic cm_owns;

   assign cm_fire = rf.rdy & rf.commit_reg_config
                  & (rf.commit_reg_id != 5'd0);
   assign is_fire = rf.rdy & rf.issue_config & ~rf.rollback
                  & (rf.issue_rd != 5'd0);

   // Commit only frees the register if it is the latest producer.
   assign cm_owns = busy_q[rf.commit_reg_id]
                  & (tag_q[rf.commit_reg_id] == rf.commit_reg_rob);

   always_comb begin
      value_d = value_q;
      busy_d  = busy_q;
      tag_d   = tag_q;
      if (cm_fire) begin
         value_d[rf.commit_reg_id] = rf.commit_reg_value;
         if (cm_owns)
            busy_d[rf.commit_reg_id] = 1'b0;
      end
      // Issue after commit so a same-register rename wins.
      if (is_fire) begin
         busy_d[rf.issue_rd] = 1'b1;
         tag_d[rf.issue_rd]  = rf.issue_rob;
      end
      if (rf.rdy && rf.rollback)
         busy_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
         busy_q  <= '0;
         tag_q   <= '0;
      end else begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   logic [1:0][4:0]       q_id;
   logic [1:0][XLEN-1:0]  q_val;
   logic [1:0]            q_busy;
   logic [1:0][ROB_W-1:0] q_tag;

   assign q_id = {rf.rs2_id, rf.rs1_id};

   // Same-cycle issue is deliberately ignored: operands are read
   // before the instruction's own destination is renamed.
   always_comb begin
      q_val  = '0;
      q_busy = '0;
      q_tag  = '0;
      for (int p = 0; p < 2; p++) begin
         if (q_id[p] != 5'd0) begin
            q_val[p]  = value_q[q_id[p]];
            q_busy[p] = busy_q[q_id[p]];
            q_tag[p]  = tag_q[q_id[p]];
            if (cm_fire && cm_owns
                && rf.commit_reg_id == q_id[p]) begin
               q_val[p]  = rf.commit_reg_value;
               q_busy[p] = 1'b0;
            end
         end
      end
   end

   assign rf.rs1_value = q_val[0];
   assign rf.rs1_busy  = q_busy[0];
   assign rf.rs1_tag   = q_tag[0];
   assign rf.rs2_value = q_val[1];
   assign rf.rs2_busy  = q_busy[1];
   assign rf.rs2_tag   = q_tag[1];
   assign rf.dbg_regs  = value_q;
endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file.
// Stimulus pushes expectations; a negedge monitor pops and checks.
module tb_reg_status_file;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_status_file_if #(.ROB_W(4), .XLEN(32)) rf_if ();

   reg_status_file #(.ROB_W(4), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf_if.slave)
   );

   typedef struct {
      string       name;
      int          port;
      int          idx;
      logic [31:0] v;
      logic        b;
      logic [3:0]  t;
      bit          ct;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] gv;
         logic        gb;
         logic [3:0]  gt;
         bit          bad;
         e = sb.pop_front();
         gv = '0; gb = 1'b0; gt = '0;
         if (e.port == 1) begin
            gv = rf_if.rs1_value;
            gb = rf_if.rs1_busy;
            gt = rf_if.rs1_tag;
         end else if (e.port == 2) begin
            gv = rf_if.rs2_value;
            gb = rf_if.rs2_busy;
            gt = rf_if.rs2_tag;
         end else begin
            gv = rf_if.dbg_regs[e.idx*32 +: 32];
         end
         n_tests++;
         bad = (gv !== e.v);
         if (e.port != 3)
            bad = bad || (gb !== e.b) || (e.ct && gt !== e.t);
         if (bad) begin
            n_fail++;
            $display("FAIL %s: got v=%h b=%0d t=%0d, want v=%h b=%0d t=%0d",
                     e.name, gv, gb, gt, e.v, e.b, e.t);
         end
      end
   end

   task automatic idle();
      rf_if.commit_reg_config = 1'b0;
      rf_if.issue_config      = 1'b0;
      rf_if.rollback          = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic commit(input logic [4:0] id,
                         input logic [31:0] v,
                         input logic [3:0] rob);
      rf_if.commit_reg_config = 1'b1;
      rf_if.commit_reg_id     = id;
      rf_if.commit_reg_value  = v;
      rf_if.commit_reg_rob    = rob;
   endtask

   task automatic issue(input logic [4:0] rd,
                        input logic [3:0] rob);
      rf_if.issue_config = 1'b1;
      rf_if.issue_rd     = rd;
      rf_if.issue_rob    = rob;
   endtask

   task automatic chk(input string n, input int port,
                      input logic [4:0] id, input logic [31:0] v,
                      input logic b, input logic [3:0] t,
                      input bit ct);
      exp_t e;
      if (port == 1) rf_if.rs1_id = id;
      if (port == 2) rf_if.rs2_id = id;
      e.name = n; e.port = port; e.idx = int'(id);
      e.v = v; e.b = b; e.t = t; e.ct = ct;
      sb.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      rf_if.rdy = 1'b1;
      idle();
      rf_if.commit_reg_id    = '0;
      rf_if.commit_reg_value = '0;
      rf_if.commit_reg_rob   = '0;
      rf_if.issue_rd         = '0;
      rf_if.issue_rob        = '0;
      rf_if.rs1_id           = '0;
      rf_if.rs2_id           = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_q1", 1, 5, 0, 0, 0, 1);
      chk("rst_q2", 2, 0, 0, 0, 0, 1);
      issue(5, 3);
      tick();
      commit(11, 32'hDEAD, 0);
      chk("iss_vis", 1, 5, 0, 1, 3, 1);
      chk("nobyp_idle", 2, 11, 0, 0, 0, 1);
      tick();
      chk("pre_rst5", 1, 5, 0, 1, 3, 1);
      chk("cm_state", 2, 11, 32'hDEAD, 0, 0, 1);
      tick();
      rst = 1'b1;
      chk("arst_5", 1, 5, 0, 0, 0, 1);
      chk("arst_11", 2, 11, 0, 0, 0, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      tick();

      issue(7, 2);
      chk("iss_same", 1, 7, 0, 0, 0, 1);
      tick();
      chk("ren7", 1, 7, 0, 1, 2, 1);
      tick();
      commit(7, 32'h1234, 2);
      chk("byp7", 1, 7, 32'h1234, 0, 2, 1);
      tick();
      chk("cm7", 1, 7, 32'h1234, 0, 2, 1);
      issue(4, 1);
      tick();
      issue(4, 6);
      tick();
      commit(4, 32'hAA, 1);
      chk("stale_q", 1, 4, 0, 1, 6, 1);
      tick();
      chk("stale", 1, 4, 32'hAA, 1, 6, 1);
      issue(9, 3);
      tick();
      commit(9, 32'h55, 3);
      issue(9, 8);
      chk("ci_byp", 1, 9, 32'h55, 0, 3, 1);
      tick();
      chk("ci9", 1, 9, 32'h55, 1, 8, 1);
      issue(1, 10);
      tick();
      issue(2, 11);
      tick();
      issue(3, 12);
      chk("b1", 1, 1, 0, 1, 10, 1);
      chk("b2", 2, 2, 0, 1, 11, 1);
      tick();
      rf_if.rollback = 1'b1;
      issue(10, 4);
      commit(2, 32'h99, 11);
      chk("rb_byp", 1, 2, 32'h99, 0, 11, 1);
      chk("rb_x3", 2, 3, 0, 1, 12, 1);
      tick();
      chk("rb1", 1, 1, 0, 0, 0, 0);
      chk("rb10", 2, 10, 0, 0, 0, 0);
      tick();
      chk("rb2", 1, 2, 32'h99, 0, 0, 0);
      chk("rb9", 2, 9, 32'h55, 0, 0, 0);
      tick();

      commit(0, 32'hFFFF, 0);
      issue(0, 5);
      chk("x0_q", 1, 0, 0, 0, 0, 1);
      tick();
      chk("x0", 1, 0, 0, 0, 0, 1);
      chk("x0_dbg", 3, 0, 0, 0, 0, 0);
      rf_if.rdy = 1'b0;
      issue(6, 5);
      chk("rdy0", 2, 6, 0, 0, 0, 0);
      tick();
      rf_if.rdy = 1'b1;
      chk("hold6", 1, 6, 0, 0, 0, 0);
      issue(6, 5);
      tick();
      chk("ren6", 1, 6, 0, 1, 5, 1);
      rf_if.rdy = 1'b0;
      commit(6, 32'h66, 5);
      chk("nobyp_rdy", 2, 6, 0, 1, 5, 1);
      tick();
      rf_if.rdy = 1'b1;
      chk("held6", 1, 6, 0, 1, 5, 1);
      tick();
      commit(6, 32'h66, 5);
      issue(20, 7);
      chk("byp6", 1, 6, 32'h66, 0, 5, 1);
      tick();
      chk("cm6", 1, 6, 32'h66, 0, 5, 1);
      chk("iss20", 2, 20, 0, 1, 7, 1);
      chk("dbg6", 3, 6, 32'h66, 0, 0, 0);
      tick();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_drain: got %0d left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
